// File: rtl/prefetch_pkg.sv
// ============================================================================
// Module      : prefetch_pkg
// Description : Shared types and constants for the instruction prefetcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prefetch_pkg;

    localparam int PHYS_ADDR_W = 20;

    typedef enum logic [2:0] {
        PF_IDLE    = 3'd0,
        PF_FETCH   = 3'd1,
        PF_PUSH_LO = 3'd2,
        PF_PUSH_HI = 3'd3,
        PF_ABORT   = 3'd4
    } pf_state_t;

endpackage

`default_nettype wire

// File: rtl/segment_address.sv
// ============================================================================
// Module      : segment_address
// Description : Real-mode CS:IP to 20-bit physical address translation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module segment_address
    import prefetch_pkg::*;
(
    input  logic [15:0]            cs,
    input  logic [15:0]            ip,
    output logic [PHYS_ADDR_W-1:0] phys
);

    // The 20-bit sum wraps naturally at 1 MiB.
    assign phys = {cs, 4'b0000} + {4'b0000, ip};

endmodule

`default_nettype wire

// File: rtl/instruction_prefetch.sv
// ============================================================================
// Module      : instruction_prefetch
// Description : Fetches aligned 16-bit words at CS:IP and pushes the useful
//               bytes into the instruction byte FIFO; flushes on CS:IP loads.
//               Optional: PREFETCH_FLUSH_COUNT_EN adds the flush_discards count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_prefetch
    import prefetch_pkg::*;
#(
    parameter logic [15:0] RESET_CS = 16'hFFFF,
    parameter logic [15:0] RESET_IP = 16'h0000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_new_cs_ip,
    input  logic [15:0] new_cs,
    input  logic [15:0] new_ip,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    input  logic        fifo_full,
    output logic        fifo_reset,
    output logic        mem_access,
    output logic [18:0] mem_address,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
`ifdef PREFETCH_FLUSH_COUNT_EN
    ,
    output logic [15:0] flush_discards
`endif
);

    pf_state_t              r_state;
    pf_state_t              w_next_state;
    logic [15:0]            r_cs;
    logic [15:0]            r_ip;
    logic [15:0]            r_data;
    logic [18:0]            r_addr;
    logic [PHYS_ADDR_W-1:0] w_phys;

    segment_address u_segment_address (
        .cs   (r_cs),
        .ip   (r_ip),
        .phys (w_phys)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= PF_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // phys[0] equals ip[0]; an odd start means the low byte of the word is dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PF_IDLE: begin
                if (!load_new_cs_ip && !fifo_full) begin
                    w_next_state = PF_FETCH;
                end
            end
            PF_FETCH: begin
                if (load_new_cs_ip) begin
                    w_next_state = mem_ack ? PF_IDLE : PF_ABORT;
                end else if (mem_ack) begin
                    w_next_state = w_phys[0] ? PF_PUSH_HI : PF_PUSH_LO;
                end
            end
            PF_PUSH_LO: begin
                if (load_new_cs_ip) begin
                    w_next_state = PF_IDLE;
                end else if (!fifo_full) begin
                    w_next_state = PF_PUSH_HI;
                end
            end
            PF_PUSH_HI: begin
                if (load_new_cs_ip || !fifo_full) begin
                    w_next_state = PF_IDLE;
                end
            end
            PF_ABORT: begin
                if (mem_ack) begin
                    w_next_state = PF_IDLE;
                end
            end
            default: w_next_state = PF_IDLE;
        endcase
    end

    always_comb begin
        mem_access   = (r_state == PF_FETCH) || (r_state == PF_ABORT);
        fifo_wr_en   = ((r_state == PF_PUSH_LO) || (r_state == PF_PUSH_HI))
                       && !fifo_full && !load_new_cs_ip;
        fifo_wr_data = (r_state == PF_PUSH_HI) ? r_data[15:8] : r_data[7:0];
        fifo_reset   = load_new_cs_ip;
        mem_address  = r_addr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs <= RESET_CS;
            r_ip <= RESET_IP;
        end else if (load_new_cs_ip) begin
            r_cs <= new_cs;
            r_ip <= new_ip;
        end else if (fifo_wr_en) begin
            r_ip <= r_ip + 16'd1;
        end
    end

    // Address is captured once at issue so it stays stable for the whole bus cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= 19'd0;
        end else if ((r_state == PF_IDLE) && (w_next_state == PF_FETCH)) begin
            r_addr <= w_phys[PHYS_ADDR_W-1:1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= 16'd0;
        end else if ((r_state == PF_FETCH) && mem_ack && !load_new_cs_ip) begin
            r_data <= mem_data;
        end
    end

`ifdef PREFETCH_FLUSH_COUNT_EN
    logic        w_discard;
    logic [15:0] r_discards;

    always_comb begin
        w_discard = (load_new_cs_ip && (((r_state == PF_FETCH) && mem_ack)
                                        || (r_state == PF_PUSH_LO)
                                        || (r_state == PF_PUSH_HI)))
                    || ((r_state == PF_ABORT) && mem_ack);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_discards <= 16'd0;
        end else if (w_discard && (r_discards != 16'hFFFF)) begin
            r_discards <= r_discards + 16'd1;
        end
    end

    assign flush_discards = r_discards;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_prefetch.sv
// ============================================================================
// Module      : tb_instruction_prefetch
// Description : Directed scoreboard bench for instruction_prefetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_prefetch;

    logic        clk;
    logic        reset;
    logic        load_new_cs_ip;
    logic [15:0] new_cs;
    logic [15:0] new_ip;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_reset;
    logic        mem_access;
    logic [18:0] mem_address;
    logic        mem_ack;
    logic [15:0] mem_data;
`ifdef PREFETCH_FLUSH_COUNT_EN
    logic [15:0] flush_discards;
`endif

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          rst_pulses = 0;
    logic [7:0]  exp_q[$];

    instruction_prefetch dut (
        .clk            (clk),
        .reset          (reset),
        .load_new_cs_ip (load_new_cs_ip),
        .new_cs         (new_cs),
        .new_ip         (new_ip),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .fifo_full      (fifo_full),
        .fifo_reset     (fifo_reset),
        .mem_access     (mem_access),
        .mem_address    (mem_address),
        .mem_ack        (mem_ack),
        .mem_data       (mem_data)
`ifdef PREFETCH_FLUSH_COUNT_EN
        ,
        .flush_discards (flush_discards)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every FIFO push must match the oldest expected byte.
    always @(negedge clk) begin
        if (reset === 1'b1 && fifo_reset === 1'b1) rst_pulses++;
        if (reset === 1'b1 && fifo_wr_en === 1'b1) begin
            wr_count++;
            chk("wr_while_full", {31'd0, fifo_full}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_push", {24'd0, fifo_wr_data}, 32'hFFFF_FFFF);
            end else begin
                chk("push_byte", {24'd0, fifo_wr_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_access(input string tag, input logic [18:0] exp_addr);
        for (int i = 0; i < 20; i++) begin
            if (mem_access) break;
            tick();
        end
        chk({tag, "_access"}, {31'd0, mem_access}, 32'd1);
        chk({tag, "_addr"}, {13'd0, mem_address}, {13'd0, exp_addr});
    endtask

    task automatic serve(input string tag, input logic [15:0] data, input int lat);
        for (int i = 0; i < lat; i++) tick();
        mem_data = data;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        chk({tag, "_access_drop"}, {31'd0, mem_access}, 32'd0);
    endtask

    // Flush coinciding with mem_ack: the flush wins, DUT returns to IDLE.
    task automatic flush_with_ack(input string tag, input logic [15:0] cs,
                                  input logic [15:0] ip, input logic [18:0] exp_addr);
        load_new_cs_ip = 1'b1;
        new_cs   = cs;
        new_ip   = ip;
        mem_ack  = 1'b1;
        mem_data = 16'hDEAD;
        #1;
        chk({tag, "_fifo_reset_hi"}, {31'd0, fifo_reset}, 32'd1);
        chk({tag, "_wr_en_lo"}, {31'd0, fifo_wr_en}, 32'd0);
        tick();
        load_new_cs_ip = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk({tag, "_fifo_reset_lo"}, {31'd0, fifo_reset}, 32'd0);
        chk({tag, "_idle"}, {31'd0, mem_access}, 32'd0);
        tick();
        chk({tag, "_refetch"}, {31'd0, mem_access}, 32'd1);
        chk({tag, "_new_addr"}, {13'd0, mem_address}, {13'd0, exp_addr});
    endtask

    initial begin
        int wr_snap;
        reset = 1'b0;
        load_new_cs_ip = 1'b0;
        new_cs = 16'h0;
        new_ip = 16'h0;
        fifo_full = 1'b0;
        mem_ack = 1'b0;
        mem_data = 16'h0;
        repeat (3) tick();

        // Reset state
        chk("rst_mem_access", {31'd0, mem_access}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_fifo_reset", {31'd0, fifo_reset}, 32'd0);
        chk("rst_mem_address", {13'd0, mem_address}, 32'd0);
`ifdef PREFETCH_FLUSH_COUNT_EN
        chk("rst_discards", {16'd0, flush_discards}, 32'd0);
`endif
        reset = 1'b1;

        // 1: reset vector fetch, both bytes pushed, ip advances to 2
        wait_access("t1", 19'h7FFF8);
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hEA);
        serve("t1", 16'hEA90, 2);
        wait_access("t1_next", 19'h7FFF9);

        // 2 (+6): flush with simultaneous ack, odd IP drops low byte
        flush_with_ack("t2", 16'h0000, 16'h0101, 19'h00080);
        chk("t2_reset_pulses", rst_pulses, 32'd1);
        exp_q.push_back(8'h34);
        serve("t2", 16'h3412, 1);
        wait_access("t2_next", 19'h00081);

        // 3: FIFO full for 3 cycles on entering PUSH_HI
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h56);
        serve("t3", 16'h5678, 1);
        tick();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_wr_en", {31'd0, fifo_wr_en}, 32'd0);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        chk("t3_release_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        chk("t3_release_byte", {24'd0, fifo_wr_data}, 32'h56);

        // 4: flush one cycle into FETCH, bus cycle runs to completion as ABORT
        wait_access("t4", 19'h00082);
        wr_snap = wr_count;
        tick();
        load_new_cs_ip = 1'b1;
        new_cs = 16'h1234;
        new_ip = 16'h0010;
        tick();
        load_new_cs_ip = 1'b0;
        chk("t4_abort_hold1", {31'd0, mem_access}, 32'd1);
        chk("t4_addr_stable", {13'd0, mem_address}, 32'h00082);
        tick();
        chk("t4_abort_hold2", {31'd0, mem_access}, 32'd1);
        tick();
        serve("t4", 16'hBEEF, 0);
        tick();
        chk("t4_no_writes", wr_count - wr_snap, 32'd0);
        chk("t4_refetch", {31'd0, mem_access}, 32'd1);
        chk("t4_new_addr", {13'd0, mem_address}, 32'h091A8);
`ifdef PREFETCH_FLUSH_COUNT_EN
        chk("t4_discards", {16'd0, flush_discards}, 32'd2);
`endif
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hAB);
        serve("t4b", 16'hABCD, 1);
        wait_access("t4_next", 19'h091A9);

        // 5: top of memory, IP wraps to zero
        flush_with_ack("t5", 16'hF000, 16'hFFFF, 19'h7FFFF);
        exp_q.push_back(8'h11);
        serve("t5", 16'h1122, 1);
        wait_access("t5_wrap", 19'h78000);
`ifdef PREFETCH_FLUSH_COUNT_EN
        chk("t5_discards", {16'd0, flush_discards}, 32'd3);
`endif
        chk("t5_reset_pulses", rst_pulses, 32'd3);

        // 6: asynchronous reset mid-FETCH
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_access", {31'd0, mem_access}, 32'd0);
        chk("t6_async_addr", {13'd0, mem_address}, 32'd0);
`ifdef PREFETCH_FLUSH_COUNT_EN
        chk("t6_discards_clr", {16'd0, flush_discards}, 32'd0);
`endif
        tick();
        reset = 1'b1;
        wait_access("t6_restart", 19'h7FFF8);
        exp_q.push_back(8'h90);
        exp_q.push_back(8'hEA);
        serve("t6", 16'hEA90, 1);
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
